// File: rtl/seg_ctrl_pkg.sv
// Shared definitions for the segment display arbiter: controller states,
// requester count, source-index width and a one-hot to index helper.
package seg_ctrl_pkg;

   localparam int NUM_SRC = 3;
   localparam int SRC_W   = 2;
   localparam int DIGIT_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Callers only pass one-hot or zero vectors; zero maps to source 0.
   function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
      logic [SRC_W-1:0] idx;
      idx = '0;
      if (oh[1]) idx = 2'd1;
      if (oh[2]) idx = 2'd2;
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant, purely combinational. The search starts one
// above the last owner and wraps, so the last owner has lowest priority.
module rr_arbiter3
   import seg_ctrl_pkg::*;
(
   input  logic [2:0]       req,
   input  logic [SRC_W-1:0] last,
   output logic [2:0]       gnt
);

   logic [SRC_W-1:0] first;
   logic [SRC_W-1:0] second;
   logic [SRC_W-1:0] third;

   // last = 3 cannot occur from the top level; treating it like 2 keeps the
   // search order well defined anyway.
   always_comb begin
      first  = 2'd0;
      second = 2'd1;
      third  = 2'd2;
      unique case (last)
         2'd0: begin
            first  = 2'd1;
            second = 2'd2;
            third  = 2'd0;
         end
         2'd1: begin
            first  = 2'd2;
            second = 2'd0;
            third  = 2'd1;
         end
         default: begin
            first  = 2'd0;
            second = 2'd1;
            third  = 2'd2;
         end
      endcase
   end

   always_comb begin
      gnt = 3'b000;
      if (req[first])
         gnt[first] = 1'b1;
      else if (req[second])
         gnt[second] = 1'b1;
      else if (req[third])
         gnt[third] = 1'b1;
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit hex display between three sources. A granted source
// owns the display for DWELL_CYCLES cycles and may refresh its value meanwhile.
module seg_display_arbiter
   import seg_ctrl_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int          NUM_SRC      = seg_ctrl_pkg::NUM_SRC
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SRC-1:0]           req_valid,
   input  logic [DIGIT_W*NUM_SRC-1:0]   req_data,
   output logic [NUM_SRC-1:0]           req_ready,
   output logic [DIGIT_W-1:0]           disp_val,
   output logic [SRC_W-1:0]             disp_src,
   output logic                         disp_busy
);

   // Handshake: a source transfers on a cycle where req_valid[i] and
   // req_ready[i] are both high. At most one ready bit is high; in IDLE ready
   // follows req_valid combinationally, in HOLD only the owner sees ready,
   // and ready is forced low while rst is high.

   localparam logic [31:0] DWELL_RELOAD = 32'(DWELL_CYCLES - 1);

   state_t           state;
   state_t           state_n;
   logic [31:0]      cnt;
   logic [31:0]      cnt_n;
   logic [SRC_W-1:0] last_owner;
   logic [2:0]       gnt;
   logic [2:0]       owner_oh;
   logic [2:0]       xfer;
   logic [SRC_W-1:0] xfer_idx;
   logic [DIGIT_W-1:0] xfer_data;

   rr_arbiter3 u_rr (
      .req  (req_valid),
      .last (last_owner),
      .gnt  (gnt)
   );

   assign owner_oh  = 3'b001 << disp_src;
   assign xfer      = req_valid & req_ready;
   assign xfer_idx  = onehot_to_idx(xfer);
   assign disp_busy = (state == HOLD);

   always_comb begin
      unique case (xfer_idx)
         2'd1:    xfer_data = req_data[2*DIGIT_W-1:DIGIT_W];
         2'd2:    xfer_data = req_data[3*DIGIT_W-1:2*DIGIT_W];
         default: xfer_data = req_data[DIGIT_W-1:0];
      endcase
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      req_ready = 3'b000;
      unique case (state)
         IDLE: begin
            req_ready = gnt;
            if (|gnt) begin
               state_n = HOLD;
               cnt_n   = DWELL_RELOAD;
            end
         end
         HOLD: begin
            // Owner refresh never reloads the counter, so the window is fixed.
            req_ready = owner_oh;
            if (cnt == 32'd0)
               state_n = IDLE;
            else
               cnt_n = cnt - 32'd1;
         end
         default: state_n = IDLE;
      endcase
      if (rst)
         req_ready = 3'b000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 32'd0;
         disp_val   <= '0;
         disp_src   <= '0;
         last_owner <= 2'd2;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (|xfer) begin
            disp_val <= xfer_data;
            disp_src <= xfer_idx;
         end
         if (state == IDLE && |xfer)
            last_owner <= xfer_idx;
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a behavioural model.
module tb_seg_display_arbiter;

   localparam int unsigned DW = 4;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [47:0] req_data;
   logic [2:0]  req_ready;
   logic [15:0] disp_val;
   logic [1:0]  disp_src;
   logic        disp_busy;

   logic [2:0]  v1;
   logic [47:0] d1;
   logic [2:0]  r1;
   logic [15:0] val1;
   logic [1:0]  src1;
   logic        busy1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [1:0] exp_q[$];

   seg_display_arbiter #(.DWELL_CYCLES(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .disp_val  (disp_val),
      .disp_src  (disp_src),
      .disp_busy (disp_busy)
   );

   seg_display_arbiter #(.DWELL_CYCLES(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (v1),
      .req_data  (d1),
      .req_ready (r1),
      .disp_val  (val1),
      .disp_src  (src1),
      .disp_busy (busy1)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The model counts remaining owned cycles directly instead of a reload value.
   int          m_busy = 0;
   int          m_left = 0;
   int          m_src  = 0;
   int          m_last = 2;
   logic [15:0] m_val  = 16'h0000;

   function automatic logic [2:0] model_ready(input logic [2:0] v);
      int idx;
      if (rst) return 3'b000;
      if (m_busy != 0) return 3'b001 << m_src;
      for (int k = 1; k <= 3; k++) begin
         idx = (m_last + k) % 3;
         if (v[idx]) return 3'b001 << idx;
      end
      return 3'b000;
   endfunction

   always @(negedge clk) begin
      logic [2:0] er;
      logic [2:0] x;
      int idx;
      if (rst) begin
         m_busy = 0; m_left = 0; m_src = 0; m_last = 2; m_val = 16'h0000;
      end
      er = model_ready(req_valid);
      chk("model_ready", {29'd0, req_ready}, {29'd0, er});
      chk("model_val",   {16'd0, disp_val},  {16'd0, m_val});
      chk("model_src",   {30'd0, disp_src},  32'(m_src));
      chk("model_busy",  {31'd0, disp_busy}, 32'(m_busy));
      if (!rst) begin
         x = req_valid & er;
         idx = 0;
         for (int i = 0; i < 3; i++) if (x[i]) idx = i;
         if (m_busy != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_busy = 0;
         end else if (x != 3'b000) begin
            m_busy = 1;
            m_left = DW;
            m_last = idx;
         end
         if (x != 3'b000) begin
            m_val = req_data[idx*16 +: 16];
            m_src = idx;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gcnt;
      int last_t;
      int t;
      rst = 1'b1;
      req_valid = 3'b000;
      req_data  = '0;
      v1 = 3'b000;
      d1 = '0;
      step();
      #1;
      chk("reset_val",  {16'd0, disp_val}, 32'h0);
      chk("reset_src",  {30'd0, disp_src}, 32'd0);
      chk("reset_busy", {31'd0, disp_busy}, 32'd0);
      chk("reset_ready", {29'd0, req_ready}, 32'd0);
      step();
      rst = 1'b0;

      // Single requester 1, then 0 and 2 wait out the dwell window.
      req_valid = 3'b010;
      req_data[31:16] = 16'h1234;
      req_data[15:0]  = 16'h0A0A;
      req_data[47:32] = 16'h2C2C;
      #1;
      chk("grant1_ready", {29'd0, req_ready}, 32'b010);
      chk("grant1_busy0", {31'd0, disp_busy}, 32'd0);
      step();
      #1;
      chk("grant1_val",  {16'd0, disp_val}, 32'h1234);
      chk("grant1_src",  {30'd0, disp_src}, 32'd1);
      chk("grant1_busy", {31'd0, disp_busy}, 32'd1);
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) begin
            req_valid = 3'b111;
            req_data[31:16] = 16'hBEEF;
         end else begin
            req_valid = 3'b101;
         end
         #1;
         chk("hold_busy", {31'd0, disp_busy}, 32'd1);
         chk("hold_no_other_ready", {29'd0, req_ready & 3'b101}, 32'd0);
         if (c == 3) chk("refresh_val", {16'd0, disp_val}, 32'hBEEF);
         step();
      end
      req_valid = 3'b101;
      #1;
      chk("after_hold_busy", {31'd0, disp_busy}, 32'd0);
      chk("wrap_grant2", {29'd0, req_ready}, 32'b100);
      step();
      #1;
      chk("grant2_src", {30'd0, disp_src}, 32'd2);
      chk("grant2_val", {16'd0, disp_val}, 32'h2C2C);
      req_valid = 3'b000;
      repeat (5) step();
      chk("idle_keeps_val", {16'd0, disp_val}, 32'h2C2C);

      // All three valid continuously from reset: grants 0,1,2,0, five cycles apart.
      rst = 1'b1;
      req_valid = 3'b111;
      step();
      rst = 1'b0;
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
      gcnt = 0;
      last_t = -1;
      t = 0;
      while (exp_q.size() > 0 && t < 40) begin
         #1;
         if (!disp_busy && req_ready != 3'b000) begin
            chk("rr_order", {29'd0, req_ready}, 32'b001 << exp_q.pop_front());
            if (last_t >= 0) chk("rr_spacing", 32'(t - last_t), DW + 1);
            last_t = t;
            gcnt++;
         end
         step();
         t++;
      end
      chk("rr_all_grants_seen", 32'(exp_q.size()), 32'd0);

      // Reset pulse mid-hold.
      do_reset();
      req_valid = 3'b100;
      req_data[47:32] = 16'hA5A5;
      step();
      req_valid = 3'b111;
      #1;
      chk("pre_rst_val", {16'd0, disp_val}, 32'hA5A5);
      step();
      rst = 1'b1;
      #1;
      chk("rst_mid_val",   {16'd0, disp_val}, 32'h0);
      chk("rst_mid_busy",  {31'd0, disp_busy}, 32'd0);
      chk("rst_mid_ready", {29'd0, req_ready}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("post_rst_prio", {29'd0, req_ready}, 32'b001);
      step();
      #1;
      chk("post_rst_src", {30'd0, disp_src}, 32'd0);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req_valid = 3'($urandom_range(0, 7));
         req_data  = {$urandom, $urandom};
         if ($urandom_range(0, 30) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end else begin
            step();
         end
      end
      req_valid = 3'b000;

      // Dwell of one cycle: a lone requester alternates IDLE and HOLD.
      d1[15:0] = 16'h00C3;
      v1 = 3'b001;
      gcnt = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("dwell1_busy", {31'd0, busy1}, 32'(c % 2));
         chk("dwell1_ready", {29'd0, r1}, 32'b001);
         if (!busy1 && r1[0]) gcnt++;
         step();
      end
      chk("dwell1_grants", 32'(gcnt), 32'd4);
      chk("dwell1_val", {16'd0, val1}, 32'h00C3);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
